// File: rtl/riscv_pkg.sv
// Shared core types: branch outcome encoding, feedback queue entry, and
// the default depth of the branch feedback queue.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package riscv_pkg;

    localparam int PC_W           = `ADDR_WIDTH;
    localparam int FB_QUEUE_DEPTH = 8;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        BranchOutcome    outcome;
    } fb_entry_t;

    // Number of entries that can be handed out at once: at most two.
    function automatic logic [1:0] take_up_to_two(input logic [7:0] avail);
        return (avail >= 8'd2) ? 2'd2 : avail[1:0];
    endfunction

endpackage

// File: rtl/branch_fb_ifc.sv
// One predictor feedback port: branch present, its PC and its resolved direction.
interface branch_fb_ifc;
    import riscv_pkg::*;

    logic            if_branch;
    logic [PC_W-1:0] branch_pc;
    BranchOutcome    outcome;

    modport out  (output if_branch, output branch_pc, output outcome);
    modport sink (input  if_branch, input  branch_pc, input  outcome);
endinterface

// File: rtl/fifo_2w2r.sv
// Circular buffer of feedback entries accepting up to two writes and
// releasing up to two reads per cycle. Writes are packed (entry 0 first).
// The read port is a combinational peek at the two oldest entries.
module fifo_2w2r
    import riscv_pkg::*;
#(
    parameter int DEPTH = FB_QUEUE_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [1:0]             wr_num_i,
    input  fb_entry_t              wr_data_i [2],
    input  logic [1:0]             rd_num_i,
    output fb_entry_t              rd_data_o [2],
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] ONE = PW'(1);

    fb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(wr_num_i);
        rd_ptr_d = rd_ptr_q + PW'(rd_num_i);
        count_d  = count_q + CW'(wr_num_i) - CW'(rd_num_i);
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are meaningless unless covered by the pointers.
    always_ff @(posedge clk_i) begin
        if (wr_num_i != 2'd0) mem_q[wr_ptr_q] <= wr_data_i[0];
        if (wr_num_i == 2'd2) mem_q[wr_ptr_q + ONE] <= wr_data_i[1];
    end

    assign rd_data_o[0] = mem_q[rd_ptr_q];
    assign rd_data_o[1] = mem_q[rd_ptr_q + ONE];
    assign count_o      = count_q;

endmodule

// File: rtl/branch_fb_gen.sv
// Branch feedback generator: queues resolved branches from two execute
// slots, replays them to the predictor two at a time through registered
// feedback ports, and flags mispredictions as they are accepted.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_fb_gen
    import riscv_pkg::*;
#(
    parameter int DEPTH      = FB_QUEUE_DEPTH,
    // Must match the PC width carried by riscv_pkg::fb_entry_t.
    parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             ex_valid,
    input  logic [ADDR_WIDTH-1:0]  ex_pc [2],
    input  BranchOutcome           ex_outcome [2],
    input  BranchOutcome           ex_pred [2],
    output logic                   ex_ready,
    branch_fb_ifc.out              o_fb [2],
    input  logic                   fb_stall,
    output logic                   mispredict,
    output logic [ADDR_WIDTH-1:0]  mispredict_pc,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    fb_entry_t             slot_ent [2];
    fb_entry_t             wr_data  [2];
    fb_entry_t             rd_data  [2];
    logic [1:0]            acc;
    logic [1:0]            wr_num;
    logic [1:0]            rd_num;
    logic                  can_load;
    logic                  mis0, mis1;

    logic                  fb0_v_q, fb0_v_d;
    logic                  fb1_v_q, fb1_v_d;
    fb_entry_t             fb0_q, fb0_d;
    fb_entry_t             fb1_q, fb1_d;
    logic                  mis_q, mis_d;
    logic [ADDR_WIDTH-1:0] mpc_q, mpc_d;
    logic                  ovf_q, ovf_d;

    // Readiness depends only on registered occupancy, never on this cycle's traffic.
    assign ex_ready = (count <= CW'(DEPTH - 2));
    assign acc      = ex_valid & {2{ex_ready}};

    // Pack accepted slots so that a lone slot 1 lands in the first write lane.
    always_comb begin
        slot_ent[0] = '{pc: PC_W'(ex_pc[0]), outcome: ex_outcome[0]};
        slot_ent[1] = '{pc: PC_W'(ex_pc[1]), outcome: ex_outcome[1]};
        wr_num      = {1'b0, acc[0]} + {1'b0, acc[1]};
        wr_data[0]  = acc[0] ? slot_ent[0] : slot_ent[1];
        wr_data[1]  = slot_ent[1];
    end

    fifo_2w2r #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (reset),
        .wr_num_i  (wr_num),
        .wr_data_i (wr_data),
        .rd_num_i  (rd_num),
        .rd_data_o (rd_data),
        .count_o   (count)
    );

    // Reload the feedback registers when they are empty or being consumed.
    // Only entries already in the queue are eligible, so a branch enqueued
    // at one edge is presented at the next edge at the earliest.
    always_comb begin
        can_load = !fb0_v_q || !fb_stall;
        rd_num   = can_load ? take_up_to_two(8'(count)) : 2'd0;
        fb0_v_d  = fb0_v_q;
        fb1_v_d  = fb1_v_q;
        fb0_d    = fb0_q;
        fb1_d    = fb1_q;
        if (can_load) begin
            fb0_v_d = (rd_num != 2'd0);
            fb1_v_d = (rd_num == 2'd2);
            fb0_d   = fb0_v_d ? rd_data[0] : '0;
            fb1_d   = fb1_v_d ? rd_data[1] : '0;
        end
    end

    // Misprediction of accepted slots only; slot 0 takes priority for the PC.
    always_comb begin
        mis0  = acc[0] && (ex_outcome[0] != ex_pred[0]);
        mis1  = acc[1] && (ex_outcome[1] != ex_pred[1]);
        mis_d = mis0 || mis1;
        mpc_d = mis0 ? ex_pc[0] : (mis1 ? ex_pc[1] : mpc_q);
        ovf_d = ovf_q || (|(ex_valid & ~{2{ex_ready}}));
    end

    // Registered feedback ports, mispredict pulse/PC and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb0_v_q <= 1'b0;
            fb1_v_q <= 1'b0;
            fb0_q   <= '0;
            fb1_q   <= '0;
            mis_q   <= 1'b0;
            mpc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            fb0_v_q <= fb0_v_d;
            fb1_v_q <= fb1_v_d;
            fb0_q   <= fb0_d;
            fb1_q   <= fb1_d;
            mis_q   <= mis_d;
            mpc_q   <= mpc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_fb[0].if_branch = fb0_v_q;
    assign o_fb[0].branch_pc = fb0_q.pc;
    assign o_fb[0].outcome   = fb0_q.outcome;
    assign o_fb[1].if_branch = fb1_v_q;
    assign o_fb[1].branch_pc = fb1_q.pc;
    assign o_fb[1].outcome   = fb1_q.outcome;

    assign mispredict    = mis_q;
    assign mispredict_pc = mpc_q;
    assign overflow_err  = ovf_q;

endmodule

// File: tb/tb_branch_fb_gen.sv
// Testbench for branch_fb_gen: directed scenarios plus a randomized stream,
// checked by a queue-based reference model and a negedge monitor.
module tb_branch_fb_gen;
    import riscv_pkg::*;

    localparam int DEPTH = FB_QUEUE_DEPTH;
    localparam int AW    = PC_W;

    logic                   clk   = 1'b0;
    logic                   reset = 1'b1;
    logic [1:0]             ex_valid = 2'b00;
    logic [AW-1:0]          ex_pc [2];
    BranchOutcome           ex_outcome [2];
    BranchOutcome           ex_pred [2];
    logic                   ex_ready;
    logic                   fb_stall = 1'b0;
    logic                   mispredict;
    logic [AW-1:0]          mispredict_pc;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow_err;

    branch_fb_ifc fb_if [2] ();

    branch_fb_gen #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_outcome    (ex_outcome),
        .ex_pred       (ex_pred),
        .ex_ready      (ex_ready),
        .o_fb          (fb_if),
        .fb_stall      (fb_stall),
        .mispredict    (mispredict),
        .mispredict_pc (mispredict_pc),
        .count         (count),
        .overflow_err  (overflow_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // exp_q holds every accepted, not yet consumed entry in age order;
    // the first m_pres of them are the ones on the feedback ports.
    fb_entry_t     exp_q[$];
    int            m_held = 0;
    int            m_pres = 0;
    logic          m_ovf  = 1'b0;
    logic          m_mis  = 1'b0;
    logic [AW-1:0] m_mpc  = '0;
    int            n_consumed = 0;

    bit        md_rdy, md_mm0, md_mm1;
    int        md_nacc, md_ld;
    fb_entry_t md_e;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            m_held = 0;
            m_pres = 0;
            m_ovf  = 1'b0;
            m_mis  = 1'b0;
            m_mpc  = '0;
        end else begin
            md_rdy  = (DEPTH - m_held) >= 2;
            md_nacc = 0;
            md_mm0  = 1'b0;
            md_mm1  = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (ex_valid[i]) begin
                    if (md_rdy) begin
                        md_e.pc      = ex_pc[i];
                        md_e.outcome = ex_outcome[i];
                        exp_q.push_back(md_e);
                        md_nacc++;
                        if (ex_outcome[i] != ex_pred[i]) begin
                            if (i == 0) md_mm0 = 1'b1;
                            else        md_mm1 = 1'b1;
                        end
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            if (m_pres == 0 || !fb_stall) begin
                md_ld  = (m_held < 2) ? m_held : 2;
                m_pres = md_ld;
                m_held = m_held - md_ld;
            end
            m_held = m_held + md_nacc;
            m_mis  = md_mm0 || md_mm1;
            if (md_mm0)      m_mpc = ex_pc[0];
            else if (md_mm1) m_mpc = ex_pc[1];
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        chk("count", 64'(count), 64'(m_held));
        chk("ex_ready", 64'(ex_ready), 64'((DEPTH - m_held) >= 2));
        chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
        chk("mispredict", 64'(mispredict), 64'(m_mis));
        chk("mispredict_pc", 64'(mispredict_pc), 64'(m_mpc));
        chk("fb0_valid", 64'(fb_if[0].if_branch), 64'(m_pres >= 1));
        chk("fb1_valid", 64'(fb_if[1].if_branch), 64'(m_pres >= 2));
        if (m_pres >= 1 && exp_q.size() >= 1) begin
            chk("fb0_pc", 64'(fb_if[0].branch_pc), 64'(exp_q[0].pc));
            chk("fb0_outcome", 64'(fb_if[0].outcome), 64'(exp_q[0].outcome));
        end else begin
            chk("fb0_idle_data", 64'({fb_if[0].branch_pc, fb_if[0].outcome}), 64'(0));
        end
        if (m_pres >= 2 && exp_q.size() >= 2) begin
            chk("fb1_pc", 64'(fb_if[1].branch_pc), 64'(exp_q[1].pc));
            chk("fb1_outcome", 64'(fb_if[1].outcome), 64'(exp_q[1].outcome));
        end else begin
            chk("fb1_idle_data", 64'({fb_if[1].branch_pc, fb_if[1].outcome}), 64'(0));
        end
        if (reset && m_pres > 0 && !fb_stall) begin
            for (int k = 0; k < m_pres; k++) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n_consumed++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v,
                         input logic [AW-1:0] pc0, input BranchOutcome o0, input BranchOutcome p0,
                         input logic [AW-1:0] pc1, input BranchOutcome o1, input BranchOutcome p1);
        ex_valid      = v;
        ex_pc[0]      = pc0;
        ex_outcome[0] = o0;
        ex_pred[0]    = p0;
        ex_pc[1]      = pc1;
        ex_outcome[1] = o1;
        ex_pred[1]    = p1;
        tick();
        ex_valid = 2'b00;
    endtask

    task automatic drain();
        ex_valid = 2'b00;
        fb_stall = 1'b0;
        for (int i = 0; i < 40 && (exp_q.size() > 0 || m_pres > 0); i++) tick();
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    logic [AW-1:0] held_pc0, held_pc1;
    int            idx, cons0, budget;
    logic [1:0]    pat;

    initial begin
        ex_pc[0] = '0; ex_pc[1] = '0;
        ex_outcome[0] = NOT_TAKEN; ex_outcome[1] = NOT_TAKEN;
        ex_pred[0] = NOT_TAKEN; ex_pred[1] = NOT_TAKEN;
        #1 reset = 1'b0;
        #2;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_ex_ready", 64'(ex_ready), 64'(1));
        chk("rst_fb0_valid", 64'(fb_if[0].if_branch), 64'(0));
        chk("rst_mispredict", 64'(mispredict), 64'(0));
        chk("rst_overflow", 64'(overflow_err), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Single enqueue, correctly predicted.
        drive(2'b01, AW'('h100), TAKEN, TAKEN, '0, NOT_TAKEN, NOT_TAKEN);
        tick();
        chk("single_fb0_valid", 64'(fb_if[0].if_branch), 64'(1));
        chk("single_fb0_pc", 64'(fb_if[0].branch_pc), 64'('h100));
        chk("single_fb0_outcome", 64'(fb_if[0].outcome), 64'(TAKEN));
        chk("single_fb1_valid", 64'(fb_if[1].if_branch), 64'(0));
        chk("single_mispredict", 64'(mispredict), 64'(0));
        drain();

        // Dual enqueue, both slots mispredicted: slot 0 PC reported.
        drive(2'b11, AW'('h200), NOT_TAKEN, TAKEN, AW'('h204), TAKEN, NOT_TAKEN);
        chk("dual_mispredict", 64'(mispredict), 64'(1));
        chk("dual_mispredict_pc", 64'(mispredict_pc), 64'('h200));
        tick();
        chk("dual_mispredict_pulse", 64'(mispredict), 64'(0));
        chk("dual_mpc_hold", 64'(mispredict_pc), 64'('h200));
        chk("dual_fb0_pc", 64'(fb_if[0].branch_pc), 64'('h200));
        chk("dual_fb1_pc", 64'(fb_if[1].branch_pc), 64'('h204));
        chk("dual_fb1_valid", 64'(fb_if[1].if_branch), 64'(1));
        drain();

        // Stall hold: presented pair held for three stalled cycles.
        drive(2'b11, AW'('h300), TAKEN, TAKEN, AW'('h304), NOT_TAKEN, NOT_TAKEN);
        tick();
        held_pc0 = fb_if[0].branch_pc;
        held_pc1 = fb_if[1].branch_pc;
        fb_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("stall_fb0_hold", 64'(fb_if[0].branch_pc), 64'('h300));
            chk("stall_fb1_hold", 64'(fb_if[1].branch_pc), 64'('h304));
            chk("stall_count", 64'(count), 64'(0));
            tick();
        end
        fb_stall = 1'b0;
        chk("stall_fb0_last", 64'(fb_if[0].branch_pc), 64'(held_pc0));
        chk("stall_fb1_last", 64'(fb_if[1].branch_pc), 64'(held_pc1));
        tick();
        chk("stall_consumed_once", 64'(fb_if[0].if_branch), 64'(0));
        drain();

        // Reset mid-operation with five queued entries and a stalled pair presented.
        fb_stall = 1'b1;
        drive(2'b11, AW'('h400), TAKEN, TAKEN, AW'('h404), TAKEN, TAKEN);
        drive(2'b11, AW'('h408), TAKEN, TAKEN, AW'('h40C), TAKEN, TAKEN);
        drive(2'b01, AW'('h410), TAKEN, NOT_TAKEN, '0, TAKEN, TAKEN);
        drive(2'b11, AW'('h414), TAKEN, TAKEN, AW'('h418), TAKEN, TAKEN);
        chk("midrst_pre_count", 64'(count), 64'(5));
        chk("midrst_pre_fb0_valid", 64'(fb_if[0].if_branch), 64'(1));
        reset = 1'b0;
        #2;
        chk("midrst_count", 64'(count), 64'(0));
        chk("midrst_ex_ready", 64'(ex_ready), 64'(1));
        chk("midrst_fb0_valid", 64'(fb_if[0].if_branch), 64'(0));
        chk("midrst_fb1_valid", 64'(fb_if[1].if_branch), 64'(0));
        chk("midrst_mispredict_pc", 64'(mispredict_pc), 64'(0));
        tick();
        reset = 1'b1;
        fb_stall = 1'b0;
        repeat (3) tick();
        chk("midrst_no_stale", 64'(fb_if[0].if_branch), 64'(0));

        // Fill and overflow under a permanent stall.
        fb_stall = 1'b1;
        for (int c = 0; c < 6; c++)
            drive(2'b11, AW'('h500 + 16 * c), TAKEN, TAKEN, AW'('h508 + 16 * c), TAKEN, TAKEN);
        chk("fill_ex_ready", 64'(ex_ready), 64'(0));
        chk("fill_overflow", 64'(overflow_err), 64'(1));
        chk("fill_count_max", 64'(count <= DEPTH), 64'(1));
        drain();
        chk("ovf_sticky", 64'(overflow_err), 64'(1));
        pulse_reset();
        chk("ovf_cleared", 64'(overflow_err), 64'(0));

        // Wrap-around: 40 PCs streamed in order under random stall.
        cons0  = n_consumed;
        idx    = 0;
        budget = 0;
        while (idx < 40 && budget < 2000) begin
            fb_stall = ($urandom_range(0, 2) == 0);
            pat = 2'b00;
            if (ex_ready) begin
                case ($urandom_range(0, 3))
                    0:       pat = 2'b00;
                    1:       pat = 2'b01;
                    2:       pat = 2'b10;
                    default: pat = (idx < 39) ? 2'b11 : 2'b01;
                endcase
            end
            ex_valid = pat;
            if (pat == 2'b10) begin
                ex_pc[1] = AW'(4 * idx);
                idx++;
            end else begin
                if (pat[0]) begin ex_pc[0] = AW'(4 * idx); idx++; end
                if (pat[1]) begin ex_pc[1] = AW'(4 * idx); idx++; end
            end
            for (int s = 0; s < 2; s++) begin
                ex_outcome[s] = BranchOutcome'($urandom_range(0, 1));
                ex_pred[s]    = BranchOutcome'($urandom_range(0, 1));
            end
            tick();
            budget++;
        end
        ex_valid = 2'b00;
        chk("wrap_all_issued", 64'(idx), 64'(40));
        drain();
        chk("wrap_consumed", 64'(n_consumed - cons0), 64'(40));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
